// File: rtl/comparator_injector_pkg.sv
// Shared definitions for the comparator scan injector: FSM state codes,
// default timing parameters and the halfstrip-to-strip reduction.
package comparator_injector_pkg;

  localparam int TIMEOUT_DEF  = 20;
  localparam int DEBOUNCE_DEF = 8;

  // Widest halfstrip bus the strip helper accepts; narrower buses are
  // zero-extended by the caller.
  localparam int MAX_HS = 256;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PULSING = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_READOUT = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // A strip is hit when either of its two halfstrips is hit.
  function automatic logic [MAX_HS/2-1:0] strip_reduce(input logic [MAX_HS-1:0] hs);
    logic [MAX_HS/2-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_HS/2; i++) s[i] = hs[2*i] | hs[2*i+1];
    return s;
  endfunction

endpackage

// File: rtl/comparator_scan_injector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             increment,
  output logic [CNT_W-1:0] value
);

  // Count up to all-ones and hold there until cleared.
  always_ff @(posedge clock) begin
    if (!rst_n)                          value <= '0;
    else if (clear)                      value <= '0;
    else if (increment && value != '1)   value <= value + CNT_W'(1);
  end

endmodule

// File: rtl/comparator_scan_injector.sv
// Comparator scan injector: pulses each halfstrip of a programmable range
// num_pulses times, checks the triad-decoded response of every pulse and
// keeps saturating error counters plus a per-point error summary.
module comparator_scan_injector
  import comparator_injector_pkg::*;
#(
  parameter  int NHS      = 32,
  parameter  int CNT_W    = 16,
  parameter  int NP_W     = 12,
  parameter  int TIMEOUT  = TIMEOUT_DEF,
  parameter  int DEBOUNCE = DEBOUNCE_DEF,
  localparam int HSW      = $clog2(NHS)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             fire_pulse,
  input  logic             scan_en,
  input  logic [HSW-1:0]   hs_first,
  input  logic [HSW-1:0]   hs_last,
  input  logic             halfstrip_mask_en,
  input  logic [NP_W-1:0]  num_pulses,
  input  logic [3:0]       pulse_width,
  input  logic [3:0]       bx_delay,
  input  logic             compin_inject,
  input  logic [NHS-1:0]   halfstrips,
  input  logic             compout,
  input  logic             compout_expect,
  input  logic             thresholds_errcnt_rst,
  input  logic             offsets_errcnt_rst,
  input  logic             compout_errcnt_rst,
  output logic             pulse_en,
  output logic             compin,
  output logic             pulser_ready,
  output logic             scan_done,
  output logic [HSW-1:0]   active_hs,
  output logic             point_done,
  output logic [NP_W-1:0]  point_errs,
  output logic [NHS-1:0]   halfstrips_last,
  output logic             compout_last,
  output logic [CNT_W-1:0] thresholds_errcnt,
  output logic [CNT_W-1:0] offsets_errcnt,
  output logic [CNT_W-1:0] compout_errcnt
);

  // Phase timer must cover both 4-bit programmable phases and the readout window.
  localparam int TW = $clog2(TIMEOUT + 16);

  // ---------------------------------------------------------------------
  // Start request conditioning
  // ---------------------------------------------------------------------
  logic                fire_meta, fire_sync;
  logic [DEBOUNCE-1:0] deb;
  logic                fire, fire_q, fire_rise;

  assign fire      = &deb;
  assign fire_rise = fire & ~fire_q;

  // Two-flop synchroniser, debounce shift register and edge detector.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      fire_meta <= 1'b0;
      fire_sync <= 1'b0;
      deb       <= '0;
      fire_q    <= 1'b0;
    end else begin
      fire_meta <= fire_pulse;
      fire_sync <= fire_meta;
      deb       <= (deb << 1) | DEBOUNCE'(fire_sync);
      fire_q    <= fire;
    end
  end

  // ---------------------------------------------------------------------
  // Response evaluation
  // ---------------------------------------------------------------------
  logic [2:0]            state;
  logic [TW-1:0]         timer;
  logic [NP_W-1:0]       pulse_cnt, np_q;
  logic [HSW-1:0]        last_q;
  logic                  scan_q;
  logic                  ready_q;
  logic                  err_thr, err_off, err_cmp;

  logic                  trigger;
  logic [NHS-1:0]        exp_mask;
  logic [MAX_HS-1:0]     hs_ext, exp_ext;
  logic                  thr_now, off_now, cmp_now, any_err_now;
  logic                  timeout_hit, readout_exit;
  logic                  point_last, step, point_start;
  logic [NP_W-1:0]       np_eff;

  assign trigger  = (|halfstrips) | compout;
  assign exp_mask = NHS'(halfstrip_mask_en) << active_hs;
  assign hs_ext   = MAX_HS'(halfstrips);
  assign exp_ext  = MAX_HS'(exp_mask);
  assign np_eff   = (num_pulses == '0) ? NP_W'(1) : num_pulses;

  // Per-pulse verdicts and FSM decision terms.
  always_comb begin
    thr_now      = strip_reduce(hs_ext) != strip_reduce(exp_ext);
    off_now      = halfstrips != exp_mask;
    cmp_now      = compout != compout_expect;
    // A lost pulse counts as an error on every verdict.
    any_err_now  = ~trigger | thr_now | off_now | cmp_now;
    timeout_hit  = timer == TW'(TIMEOUT - 1);
    readout_exit = (state == ST_READOUT) && (trigger || timeout_hit);
    point_last   = (state == ST_CHECK) && (pulse_cnt >= np_q);
    step         = point_last && scan_q && (active_hs < last_q);
    point_start  = ((state == ST_IDLE) && fire_rise) || step;
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  // Pulse/delay/readout/check sequence with automatic halfstrip stepping.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      pulse_cnt <= '0;
      np_q      <= '0;
      last_q    <= '0;
      scan_q    <= 1'b0;
      active_hs <= '0;
      err_thr   <= 1'b0;
      err_off   <= 1'b0;
      err_cmp   <= 1'b0;
    end else begin
      timer <= timer + TW'(1);
      case (state)
        ST_IDLE: begin
          if (fire_rise) begin
            state     <= ST_PULSING;
            timer     <= '0;
            active_hs <= hs_first;
            last_q    <= hs_last;
            scan_q    <= scan_en;
            np_q      <= np_eff;
            pulse_cnt <= NP_W'(1);
          end
        end
        ST_PULSING: begin
          if (timer == TW'(pulse_width)) begin
            state <= ST_DELAY;
            timer <= '0;
          end
        end
        ST_DELAY: begin
          if (timer == TW'(bx_delay)) begin
            state <= ST_READOUT;
            timer <= '0;
          end
        end
        ST_READOUT: begin
          if (readout_exit) begin
            state   <= ST_CHECK;
            err_thr <= ~trigger | thr_now;
            err_off <= ~trigger | off_now;
            err_cmp <= ~trigger | cmp_now;
          end
        end
        ST_CHECK: begin
          timer <= '0;
          if (!point_last) begin
            state     <= ST_PULSING;
            pulse_cnt <= pulse_cnt + NP_W'(1);
          end else if (step) begin
            state     <= ST_PULSING;
            active_hs <= active_hs + HSW'(1);
            pulse_cnt <= NP_W'(1);
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Ready is held low through the reset cycle so every output starts at 0.
  always_ff @(posedge clock) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Capture the most recent triggered response regardless of state.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      halfstrips_last <= '0;
      compout_last    <= 1'b0;
    end else if (trigger) begin
      halfstrips_last <= halfstrips;
      compout_last    <= compout;
    end
  end

  assign pulse_en     = state == ST_PULSING;
  assign compin       = (state == ST_PULSING) & compin_inject;
  assign pulser_ready = ready_q & (state == ST_IDLE);
  assign scan_done    = state == ST_DONE;
  assign point_done   = point_last;

  // ---------------------------------------------------------------------
  // Error accounting
  // ---------------------------------------------------------------------
  // Verdicts latched at readout exit are counted during CHECK.
  sat_counter #(.CNT_W(CNT_W)) u_thr_cnt (
    .clock     (clock),
    .rst_n     (rst_n),
    .clear     (thresholds_errcnt_rst),
    .increment ((state == ST_CHECK) & err_thr),
    .value     (thresholds_errcnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_off_cnt (
    .clock     (clock),
    .rst_n     (rst_n),
    .clear     (offsets_errcnt_rst),
    .increment ((state == ST_CHECK) & err_off),
    .value     (offsets_errcnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cmp_cnt (
    .clock     (clock),
    .rst_n     (rst_n),
    .clear     (compout_errcnt_rst),
    .increment ((state == ST_CHECK) & err_cmp),
    .value     (compout_errcnt)
  );

  // Counted at readout exit so the last pulse is included when point_done fires.
  sat_counter #(.CNT_W(NP_W)) u_point_cnt (
    .clock     (clock),
    .rst_n     (rst_n),
    .clear     (point_start),
    .increment (readout_exit & any_err_now),
    .value     (point_errs)
  );

endmodule

// File: tb/tb_comparator_scan_injector.sv
// Scoreboard bench: each run pushes the expected per-point results derived
// from the scan rules; a monitor pops them on every point_done strobe.
module tb_comparator_scan_injector;
  localparam int NHS = 32, HSW = 5, NP_W = 12, CNT_W = 16, TIMEOUT = 20;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic fire_pulse = 1'b0, scan_en = 1'b0, halfstrip_mask_en = 1'b0;
  logic compin_inject = 1'b0, compout_expect = 1'b0;
  logic [HSW-1:0] hs_first = '0, hs_last = '0;
  logic [NP_W-1:0] num_pulses = '0;
  logic [3:0] pulse_width = '0, bx_delay = '0;
  logic thr_rst = 1'b0, off_rst = 1'b0, cmp_rst = 1'b0;
  logic [NHS-1:0] halfstrips;
  logic compout;

  logic pulse_en, compin, pulser_ready, scan_done, point_done, compout_last;
  logic [HSW-1:0] active_hs;
  logic [NP_W-1:0] point_errs;
  logic [NHS-1:0] halfstrips_last;
  logic [CNT_W-1:0] thr_cnt, off_cnt, cmp_cnt;

  logic pulse_en_4, compin_4, pulser_ready_4, scan_done_4, point_done_4, compout_last_4;
  logic [HSW-1:0] active_hs_4;
  logic [NP_W-1:0] point_errs_4;
  logic [NHS-1:0] halfstrips_last_4;
  logic [3:0] thr_cnt_4, off_cnt_4, cmp_cnt_4;

  comparator_scan_injector dut (
    .clock(clock), .rst_n(rst_n), .fire_pulse(fire_pulse), .scan_en(scan_en),
    .hs_first(hs_first), .hs_last(hs_last), .halfstrip_mask_en(halfstrip_mask_en),
    .num_pulses(num_pulses), .pulse_width(pulse_width), .bx_delay(bx_delay),
    .compin_inject(compin_inject), .halfstrips(halfstrips), .compout(compout),
    .compout_expect(compout_expect), .thresholds_errcnt_rst(thr_rst),
    .offsets_errcnt_rst(off_rst), .compout_errcnt_rst(cmp_rst),
    .pulse_en(pulse_en), .compin(compin), .pulser_ready(pulser_ready),
    .scan_done(scan_done), .active_hs(active_hs), .point_done(point_done),
    .point_errs(point_errs), .halfstrips_last(halfstrips_last),
    .compout_last(compout_last), .thresholds_errcnt(thr_cnt),
    .offsets_errcnt(off_cnt), .compout_errcnt(cmp_cnt)
  );

  comparator_scan_injector #(.CNT_W(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .fire_pulse(fire_pulse), .scan_en(scan_en),
    .hs_first(hs_first), .hs_last(hs_last), .halfstrip_mask_en(halfstrip_mask_en),
    .num_pulses(num_pulses), .pulse_width(pulse_width), .bx_delay(bx_delay),
    .compin_inject(compin_inject), .halfstrips(halfstrips), .compout(compout),
    .compout_expect(compout_expect), .thresholds_errcnt_rst(thr_rst),
    .offsets_errcnt_rst(off_rst), .compout_errcnt_rst(cmp_rst),
    .pulse_en(pulse_en_4), .compin(compin_4), .pulser_ready(pulser_ready_4),
    .scan_done(scan_done_4), .active_hs(active_hs_4), .point_done(point_done_4),
    .point_errs(point_errs_4), .halfstrips_last(halfstrips_last_4),
    .compout_last(compout_last_4), .thresholds_errcnt(thr_cnt_4),
    .offsets_errcnt(off_cnt_4), .compout_errcnt(cmp_cnt_4)
  );

  always #5 clock = ~clock;

  // Bench state
  typedef struct { int hs; int errs; } point_t;
  point_t sb[$];
  int rises[$];
  int cyc = 0;
  int checks = 0, errors = 0;
  longint tot_thr = 0, tot_off = 0, tot_cmp = 0;
  int md = 0;              // responder: 0 silent, 1 echo hs, 2 echo hs+1, 3 fixed pattern
  logic [31:0] pt = '0;
  logic cv = 1'b0;
  logic pe_q = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] resp_of(input int m, input int hs);
    case (m)
      0:       return 32'h0;
      1:       return 32'(1) << hs;
      2:       return (hs + 1 < 32) ? (32'(1) << (hs + 1)) : 32'h0;
      default: return pt;
    endcase
  endfunction

  // Set of strips touched by a halfstrip pattern: halfstrip j lives in strip j/2.
  function automatic logic [15:0] strip_set(input logic [31:0] h);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < 32; j++) if (h[j]) s[j / 2] = 1'b1;
    return s;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Front-end model: answers with a pattern chosen by the current run mode.
  always @(negedge clock) begin
    halfstrips = resp_of(md, int'(active_hs));
    compout    = (md != 0) ? cv : 1'b0;
  end

  // Monitor: pulse starts and point results against the scoreboard.
  always @(negedge clock) begin
    point_t r;
    if (rst_n) begin
      if (pulse_en && !pe_q) begin
        rises.push_back(cyc);
        check("compin_level", compin, compin_inject);
      end
      if (point_done) begin
        if (sb.size() == 0) check("unexpected_point_done", 1, 0);
        else begin
          r = sb.pop_front();
          check("point_hs", active_hs, r.hs);
          check("point_errs", point_errs, r.errs);
        end
      end
    end
    pe_q = pulse_en;
  end

  task automatic chk_counters(input string tag);
    check({tag, "_thr"},  thr_cnt,   sat(tot_thr, 65535));
    check({tag, "_off"},  off_cnt,   sat(tot_off, 65535));
    check({tag, "_cmp"},  cmp_cnt,   sat(tot_cmp, 65535));
    check({tag, "_thr4"}, thr_cnt_4, sat(tot_thr, 15));
    check({tag, "_off4"}, off_cnt_4, sat(tot_off, 15));
    check({tag, "_cmp4"}, cmp_cnt_4, sat(tot_cmp, 15));
  endtask

  task automatic clear_counters();
    @(posedge clock); #1;
    thr_rst = 1'b1; off_rst = 1'b1; cmp_rst = 1'b1;
    @(posedge clock); #1;
    thr_rst = 1'b0; off_rst = 1'b0; cmp_rst = 1'b0;
    tot_thr = 0; tot_off = 0; tot_cmp = 0;
  endtask

  // One complete run with the currently applied configuration.
  task automatic run_it(input bit clr_mode, input bit keep_fire, input string tag);
    int pts[$];
    int npe, budget, c0, npts, exp_gap;
    logic [31:0] r, em;
    bit trig, et, eo, ec, seen, first_trig;
    npe = (num_pulses == 0) ? 1 : int'(num_pulses);
    if (scan_en && hs_first <= hs_last)
      for (int h = int'(hs_first); h <= int'(hs_last); h++) pts.push_back(h);
    else
      pts.push_back(int'(hs_first));
    npts = pts.size();
    first_trig = 1'b0;
    foreach (pts[i]) begin
      r    = resp_of(md, pts[i]);
      em   = halfstrip_mask_en ? (32'(1) << pts[i]) : 32'h0;
      trig = (r != 0) || (md != 0 && cv);
      et   = !trig || (strip_set(r) != strip_set(em));
      eo   = !trig || (r != em);
      ec   = !trig || (((md != 0) ? cv : 1'b0) != compout_expect);
      if (i == 0) first_trig = trig;
      tot_thr += et ? npe : 0;
      tot_off += eo ? npe : 0;
      tot_cmp += ec ? npe : 0;
      sb.push_back('{pts[i], (et || eo || ec) ? npe : 0});
    end
    exp_gap = (int'(pulse_width) + 1) + (int'(bx_delay) + 1) + (first_trig ? 1 : TIMEOUT) + 1;
    if (clr_mode) begin thr_rst = 1'b1; off_rst = 1'b1; cmp_rst = 1'b1; end
    rises.delete();
    @(posedge clock); #1;
    c0 = cyc;
    fire_pulse = 1'b1;
    budget = npts * npe * 60 + 200;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clock);
      if (clr_mode && point_done) begin
        @(posedge clock); #1;
        thr_rst = 1'b0; off_rst = 1'b0; cmp_rst = 1'b0;
      end else if (scan_done) seen = 1'b1;
    end
    check({tag, "_scan_done"}, seen, 1);
    if (!keep_fire) begin @(posedge clock); #1; fire_pulse = 1'b0; end
    repeat (keep_fire ? 60 : 15) @(posedge clock);
    @(negedge clock);
    check({tag, "_pulses"}, rises.size(), npts * npe);
    if (rises.size() > 0) check({tag, "_start_latency"}, rises[0] - c0, 11);
    if (rises.size() > 1) check({tag, "_pulse_gap"}, rises[1] - rises[0], exp_gap);
    check({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
    if (clr_mode) begin tot_thr = 0; tot_off = 0; tot_cmp = 0; end
    chk_counters(tag);
    if (md != 0) begin
      check({tag, "_hs_last"}, halfstrips_last, resp_of(md, pts[npts - 1]));
      check({tag, "_compout_last"}, compout_last, cv);
    end
    if (keep_fire) begin
      fire_pulse = 1'b0;
      repeat (15) @(posedge clock);
    end
  endtask

  task automatic cfg(input bit sc, input int f, input int l, input int np, input int pw,
                     input int bd, input int m, input bit me, input bit c, input bit ce);
    @(posedge clock); #1;
    scan_en = sc; hs_first = HSW'(f); hs_last = HSW'(l); num_pulses = NP_W'(np);
    pulse_width = 4'(pw); bx_delay = 4'(bd); md = m; halfstrip_mask_en = me;
    cv = c; compout_expect = ce; compin_inject = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int f, l, ok;
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_pulse_en", pulse_en, 0);
    check("rst_ready", pulser_ready, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_point_done", point_done, 0);
    check("rst_active_hs", active_hs, 0);
    check("rst_point_errs", point_errs, 0);
    check("rst_hs_last", halfstrips_last, 0);
    chk_counters("rst");
    @(posedge clock); #1; rst_n = 1'b1;
    @(posedge clock); @(negedge clock);
    check("ready_after_rst", pulser_ready, 1);

    // Clean single point: echo of the target halfstrip
    cfg(0, 5, 5, 3, 1, 2, 1, 1, 1, 1);
    run_it(0, 0, "single5");

    // Full scan with a one-off echo: odd points miss the strip too
    clear_counters();
    cfg(1, 0, 31, 1, 0, 0, 2, 1, 1, 1);
    run_it(0, 0, "scan_all");
    check("scan_all_off_total", off_cnt, 32);
    check("scan_all_thr_total", thr_cnt, 16);

    // Silent front-end: every pulse times out
    clear_counters();
    cfg(0, 3, 3, 3, 2, 1, 0, 1, 0, 0);
    run_it(0, 0, "timeout");

    // Inverted range runs only hs_first; zero pulses means one
    cfg(1, 10, 4, 2, 0, 3, 1, 1, 1, 0);
    run_it(0, 0, "inv_range");
    cfg(0, 20, 0, 0, 1, 1, 1, 0, 0, 0);
    run_it(0, 0, "np_zero");

    // Randomised runs
    for (int n = 0; n < 10; n++) begin
      f = $urandom_range(0, 31);
      l = f + $urandom_range(0, 5) - 1;
      if (l < 0) l = 0;
      if (l > 31) l = 31;
      cfg(1'($urandom_range(0, 1)), f, l, $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pt = $urandom_range(0, 1) ? (32'(1) << $urandom_range(0, 31)) : 32'($urandom);
      run_it(0, 0, "rand");
    end

    // Saturation: 20 failing pulses on a 4-bit counter
    clear_counters();
    cfg(0, 9, 9, 20, 0, 0, 0, 1, 0, 0);
    run_it(0, 0, "saturate");

    // Reset during DELAY aborts the run and clears counters
    cfg(0, 7, 7, 3, 1, 12, 0, 1, 0, 0);
    rises.delete();
    @(posedge clock); #1; fire_pulse = 1'b1;
    ok = 0;
    for (int k = 0; k < 60 && ok == 0; k++) begin @(negedge clock); if (pulse_en) ok = 1; end
    for (int k = 0; k < 30 && ok == 1; k++) begin @(negedge clock); if (!pulse_en) ok = 2; end
    check("rst_mid_reached_delay", ok, 2);
    @(negedge clock);
    @(posedge clock); #1; rst_n = 1'b0; fire_pulse = 1'b0;
    @(posedge clock); @(negedge clock);
    sb.delete(); tot_thr = 0; tot_off = 0; tot_cmp = 0;
    check("rst_mid_pulse_en", pulse_en, 0);
    check("rst_mid_ready", pulser_ready, 0);
    check("rst_mid_point_errs", point_errs, 0);
    chk_counters("rst_mid");
    @(posedge clock); #1; rst_n = 1'b1;
    @(posedge clock); @(negedge clock);
    check("rst_mid_idle", pulser_ready, 1);
    repeat (15) @(posedge clock);

    // Clear asserted across the increment cycle wins
    cfg(0, 2, 2, 1, 0, 0, 0, 1, 0, 0);
    run_it(1, 0, "clr_prio");

    // Short glitch on fire_pulse never starts a run
    rises.delete();
    @(posedge clock); #1; fire_pulse = 1'b1;
    repeat (7) @(posedge clock);
    #1; fire_pulse = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("glitch_no_run", rises.size(), 0);
    check("glitch_ready", pulser_ready, 1);

    // fire_pulse held high through DONE gives one run only
    cfg(1, 12, 14, 1, 0, 0, 1, 1, 1, 1);
    run_it(0, 1, "hold_fire");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
